seg7_scan_display: RTL and testbench
====================================

# seg7_scan_display

Parametrised multiplexed seven-segment display controller. It generalises the board's fixed 4-digit hex debug display to DIGITS digits. It adds a sequential binary-to-decimal mode, leading-zero blanking, a per-digit decimal-point mask, an enable, and a capture/busy handshake. It sits at the board top level and shows a debug value such as the core's data address or PC on the 7-segment bank.

## Interface
- DIGITS, 4: number of digits, 1..8
- REFRESH_DIV, 100000: clk cycles per digit slot, ≥2
- ACTIVE_LOW, 1: 1 means segments, anodes and dp are active-low (Basys3); 0 means active-high

- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high
- value  in  4*DIGITS  binary value to display
- value_valid  in  1  capture request
- bcd_mode  in  1  0 = hex, 1 = decimal; sampled only at capture
- blank_lz  in  1  leading-zero blanking; live, not captured
- dp_mask  in  DIGITS  dp on for digit i when bit i = 1; live
- enable  in  1  0 = display dark
- busy  out  1  decimal conversion in progress
- overflow  out  1  last decimal capture exceeded 10^DIGITS−1
- led_segment  out  7  bit0 = a … bit6 = g
- anode_activate  out  DIGITS  bit i selects digit i; digit 0 is rightmost (least significant)
- dp  out  1  decimal point

## Operation
**Capture**
- Capture occurs when value_valid && !busy. value_valid while busy is dropped, with no queueing.
- Hex capture: the display register (DIGITS nibbles) loads value directly. busy stays 0.

**Decimal conversion**
- Shift-add-3 (double-dabble), one bit per cycle, over 4*DIGITS shifts.
- The internal BCD accumulator is DIGITS+2 digits wide, which is enough for 16^DIGITS.
- If any of the upper 2 BCD digits is nonzero, overflow = 1 and every digit shows a dash. Otherwise overflow = 0 and the display register loads the low DIGITS BCD digits.
- overflow is cleared by any hex capture.
- The display register holds its old contents until the conversion completes.

**Scan**
- A refresh counter runs 0..REFRESH_DIV−1. At the terminal count the scan index increments, wrapping DIGITS−1 → 0.
- Scan and counter run regardless of enable and busy.

**Glyphs** (active-high codes, {g..a}; inverted when ACTIVE_LOW)
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
- 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71, dash=40

**Blanking and enables**
- Leading-zero blanking: digit i>0 is blanked (anode inactive) when blank_lz=1 and nibbles i..DIGITS−1 are all 0. It does not apply in the overflow dash display.
- Digit 0 is never blanked.
- dp is active when dp_mask[scan index]=1, enable=1 and the digit is not blanked.
- enable=0: all anodes inactive, segments off, dp off.

## Timing
**Reset values**
- busy=0, overflow=0, display register=0, scan index=0, refresh counter=0.
- anode_activate all inactive, led_segment all off, dp off.

**Outputs and scan**
- led_segment, anode_activate and dp are registered. They reflect scan index and display register one cycle late.
- The first digit is shown on the cycle after reset deasserts.
- Exactly one anode is active at a time; none when blanked or disabled.
- Each digit slot lasts exactly REFRESH_DIV cycles. A full frame is DIGITS*REFRESH_DIV cycles.

**Hex capture**
- A capture at edge N updates the display register at N. The change is visible on the pins from edge N+1 whenever that digit is scanned.

**Decimal capture**
- A capture at edge N loads the shifter. Edges N+1..N+4*DIGITS perform the shifts.
- At edge N+4*DIGITS the display register and overflow update and busy falls.
- busy is high for exactly 4*DIGITS cycles.
- A new capture is accepted in the first cycle busy is low.

**Reset mid-conversion**
- Aborts the conversion, busy=0, display register=0, overflow=0.

**Mode sampling**
- bcd_mode changes during a conversion have no effect.

## Test plan
1. DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1, hex capture 0x1A3F → anode 1110/seg 0x0E (F), 1101/0x30 (3), 1011/0x08 (A), 0111/0x79 (1). Each holds 4 cycles, then the sequence repeats.
2. Decimal capture 0x04D2 → busy=1 for exactly 16 cycles. Then digits 0..3 show 4,3,2,1 and overflow=0. A value_valid pulse mid-conversion is ignored.
3. Decimal 0x2710 (10000) → overflow=1 and all four digits show seg 0x3F (dash). A following hex capture 0x0000 clears overflow.
4. blank_lz=1, hex 0x0005 → only anode 1110 is ever active, showing 5. Hex 0x0000 → digit 0 shows 0. Hex 0x0105 → digits 0..2 lit, digit 3 dark.
5. dp_mask=0100 → dp low only while anode 1011. With enable=0, anodes stay 1111, seg 0x7F, dp 1, while the scan index keeps advancing.
6. Reset asserted 5 cycles into a decimal conversion → next cycle busy=0, overflow=0, all outputs off. After release, digit 0 shows 0.

Source files
------------

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: multiplexed seven-segment controller for DIGITS digits.
// Hex or double-dabble decimal capture into a display register, a fixed-rate
// digit scan, leading-zero blanking, per-digit decimal points and registered
// pin outputs in either polarity.
module seg7_scan_display #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  value_valid,
    input  logic                  bcd_mode,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic                  enable,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            led_segment,
    output logic [DIGITS-1:0]     anode_activate,
    output logic                  dp
);

    localparam int VW  = 4 * DIGITS;
    localparam int BW  = 4 * (DIGITS + 2);
    localparam int SW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW  = $clog2(REFRESH_DIV);
    localparam int NW  = $clog2(VW + 1);
    localparam bit INV = (ACTIVE_LOW != 0);

    logic [VW-1:0]     disp;
    logic [VW-1:0]     bin;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     bcd_adj;
    logic [BW-1:0]     bcd_next;
    logic [NW-1:0]     shift_cnt;
    logic              last_shift;
    logic [CW-1:0]     refresh_cnt;
    logic [SW-1:0]     scan_idx;
    logic [3:0]        nib;
    logic              blank;
    logic              lit;
    logic [6:0]        glyph;
    logic [6:0]        seg_on;
    logic [DIGITS-1:0] anode_on;
    logic              dp_on;

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0: seg_code = 7'h3F;
            4'h1: seg_code = 7'h06;
            4'h2: seg_code = 7'h5B;
            4'h3: seg_code = 7'h4F;
            4'h4: seg_code = 7'h66;
            4'h5: seg_code = 7'h6D;
            4'h6: seg_code = 7'h7D;
            4'h7: seg_code = 7'h07;
            4'h8: seg_code = 7'h7F;
            4'h9: seg_code = 7'h6F;
            4'hA: seg_code = 7'h77;
            4'hB: seg_code = 7'h7C;
            4'hC: seg_code = 7'h39;
            4'hD: seg_code = 7'h5E;
            4'hE: seg_code = 7'h79;
            default: seg_code = 7'h71;
        endcase
    endfunction

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift in the next binary bit
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < DIGITS + 2; k++) begin
            if (bcd_adj[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_adj[4*k +: 4] + 4'd3;
            end
        end
        bcd_next   = {bcd_adj[BW-2:0], bin[VW-1]};
        last_shift = (shift_cnt == NW'(VW - 1));
    end

    // Capture handshake, decimal conversion and display register update
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            overflow  <= 1'b0;
            disp      <= '0;
            bin       <= '0;
            bcd       <= '0;
            shift_cnt <= '0;
        end else if (busy) begin
            bin       <= bin << 1;
            bcd       <= bcd_next;
            shift_cnt <= shift_cnt + NW'(1);
            if (last_shift) begin
                busy <= 1'b0;
                // The two guard digits catch values past 10^DIGITS-1; display keeps old contents then
                if (bcd_next[BW-1 -: 8] != 8'h00) begin
                    overflow <= 1'b1;
                end else begin
                    overflow <= 1'b0;
                    disp     <= bcd_next[VW-1:0];
                end
            end
        end else if (value_valid) begin
            if (bcd_mode) begin
                bin       <= value;
                bcd       <= '0;
                shift_cnt <= '0;
                busy      <= 1'b1;
            end else begin
                disp     <= value;
                overflow <= 1'b0;
            end
        end
    end

    // Refresh counter and digit scan index, free-running
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
        end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            scan_idx    <= (scan_idx == SW'(DIGITS - 1)) ? '0 : scan_idx + SW'(1);
        end else begin
            refresh_cnt <= refresh_cnt + CW'(1);
        end
    end

    // Glyph selection, blanking and enable gating for the digit currently scanned
    always_comb begin
        nib      = disp[{scan_idx, 2'b00} +: 4];
        blank    = blank_lz && !overflow && (scan_idx != '0) &&
                   ((disp >> {scan_idx, 2'b00}) == '0);
        lit      = enable && !blank;
        glyph    = overflow ? 7'h40 : seg_code(nib);
        seg_on   = lit ? glyph : 7'h00;
        anode_on = lit ? (DIGITS'(1) << scan_idx) : '0;
        dp_on    = lit && dp_mask[scan_idx];
    end

    // Registered pins, polarity applied last so reset drives them inactive
    always_ff @(posedge clk) begin
        if (reset) begin
            led_segment    <= {7{INV}};
            anode_activate <= {DIGITS{INV}};
            dp             <= INV;
        end else begin
            led_segment    <= seg_on ^ {7{INV}};
            anode_activate <= anode_on ^ {DIGITS{INV}};
            dp             <= dp_on ^ INV;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with DIGITS=4, REFRESH_DIV=4, active-low pins.
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        value_valid;
    logic        bcd_mode;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic        enable;
    logic        busy;
    logic        overflow;
    logic [6:0]  led_segment;
    logic [3:0]  anode_activate;
    logic        dp;

    int errors = 0;
    int checks = 0;

    seg7_scan_display #(.DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut (
        .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
        .bcd_mode(bcd_mode), .blank_lz(blank_lz), .dp_mask(dp_mask), .enable(enable),
        .busy(busy), .overflow(overflow), .led_segment(led_segment),
        .anode_activate(anode_activate), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [15:0] v, input logic mode);
        value       = v;
        bcd_mode    = mode;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        bcd_mode    = 1'b0;
    endtask

    // Counts cycles with busy high; optionally pulses a decimal request mid-way
    task automatic wait_busy(input int inject_at, output int n);
        n = 0;
        while (busy && n < 40) begin
            if (n == inject_at) begin
                value       = 16'hFFFF;
                bcd_mode    = 1'b1;
                value_valid = 1'b1;
            end else begin
                value_valid = 1'b0;
                bcd_mode    = 1'b0;
            end
            n++;
            tick();
        end
        value_valid = 1'b0;
        bcd_mode    = 1'b0;
    endtask

    // Aligns to the first cycle of digit slot 0, then checks one full 16-cycle frame
    task automatic check_frame(input string name, input logic [3:0] ea[4],
                               input logic [6:0] es[4], input logic ed[4]);
        logic [3:0] prev;
        int         n;
        prev = anode_activate;
        n    = 0;
        tick();
        while (!(anode_activate == ea[0] && prev != ea[0]) && n < 40) begin
            prev = anode_activate;
            tick();
            n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL %s sync: anode never reached %b", name, ea[0]);
        end else begin
            for (int c = 0; c < 16; c++) begin
                if (c != 0) tick();
                checks++;
                if (anode_activate !== ea[c/4] || led_segment !== es[c/4] || dp !== ed[c/4]) begin
                    errors++;
                    $display("FAIL %s cycle %0d: anode=%b seg=%h dp=%b, want anode=%b seg=%h dp=%b",
                             name, c, anode_activate, led_segment, dp, ea[c/4], es[c/4], ed[c/4]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; value = '0; value_valid = 1'b0; bcd_mode = 1'b0;
        blank_lz = 1'b0; dp_mask = 4'b0000; enable = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || overflow !== 1'b0 || anode_activate !== 4'b1111 ||
            led_segment !== 7'h7F || dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: busy=%b ovf=%b anode=%b seg=%h dp=%b, want 0 0 1111 7f 1",
                     busy, overflow, anode_activate, led_segment, dp);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (anode_activate !== 4'b1110 || led_segment !== 7'h40 || dp !== 1'b1) begin
            errors++;
            $display("FAIL first_digit: anode=%b seg=%h dp=%b, want 1110 40 1",
                     anode_activate, led_segment, dp);
        end
    endtask

    task automatic test_hex();
        capture(16'h1A3F, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hex_busy: busy=%b want 0", busy);
        end
        check_frame("hex_1a3f", '{4'b1110, 4'b1101, 4'b1011, 4'b0111},
                    '{7'h0E, 7'h30, 7'h08, 7'h79}, '{1'b1, 1'b1, 1'b1, 1'b1});
    endtask

    task automatic test_decimal();
        int n;
        capture(16'h04D2, 1'b1);
        wait_busy(5, n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL dec_busy_len: got %0d cycles want 16", n);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL dec_overflow: got %b want 0", overflow);
        end
        check_frame("dec_1234", '{4'b1110, 4'b1101, 4'b1011, 4'b0111},
                    '{7'h19, 7'h30, 7'h24, 7'h79}, '{1'b1, 1'b1, 1'b1, 1'b1});
    endtask

    task automatic test_blank();
        blank_lz = 1'b1;
        capture(16'h0005, 1'b0);
        check_frame("blank_0005", '{4'b1110, 4'b1111, 4'b1111, 4'b1111},
                    '{7'h12, 7'h7F, 7'h7F, 7'h7F}, '{1'b1, 1'b1, 1'b1, 1'b1});
        capture(16'h0000, 1'b0);
        check_frame("blank_0000", '{4'b1110, 4'b1111, 4'b1111, 4'b1111},
                    '{7'h40, 7'h7F, 7'h7F, 7'h7F}, '{1'b1, 1'b1, 1'b1, 1'b1});
        capture(16'h0105, 1'b0);
        check_frame("blank_0105", '{4'b1110, 4'b1101, 4'b1011, 4'b1111},
                    '{7'h12, 7'h40, 7'h79, 7'h7F}, '{1'b1, 1'b1, 1'b1, 1'b1});
        capture(16'h0000, 1'b0);
    endtask

    task automatic test_overflow();
        int n;
        capture(16'h2710, 1'b1);
        wait_busy(-1, n);
        checks++;
        if (n !== 16 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: busy cycles=%0d ovf=%b, want 16 1", n, overflow);
        end
        check_frame("ovf_dash", '{4'b1110, 4'b1101, 4'b1011, 4'b0111},
                    '{7'h3F, 7'h3F, 7'h3F, 7'h3F}, '{1'b1, 1'b1, 1'b1, 1'b1});
        capture(16'h0000, 1'b0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear_by_hex: got %b want 0", overflow);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        capture(16'h2710, 1'b1);
        wait_busy(-1, n);
        capture(16'h0063, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b want 1", busy);
        end
        wait_busy(-1, n);
        checks++;
        if (n !== 16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: busy cycles=%0d ovf=%b, want 16 0", n, overflow);
        end
        check_frame("b2b_99", '{4'b1110, 4'b1101, 4'b1111, 4'b1111},
                    '{7'h10, 7'h10, 7'h7F, 7'h7F}, '{1'b1, 1'b1, 1'b1, 1'b1});
    endtask

    task automatic test_dp_enable();
        blank_lz = 1'b0;
        dp_mask  = 4'b0100;
        capture(16'h1A3F, 1'b0);
        check_frame("dp_mask", '{4'b1110, 4'b1101, 4'b1011, 4'b0111},
                    '{7'h0E, 7'h30, 7'h08, 7'h79}, '{1'b1, 1'b1, 1'b0, 1'b1});
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (anode_activate !== 4'b1111 || led_segment !== 7'h7F || dp !== 1'b1) begin
                errors++;
                $display("FAIL disabled cycle %0d: anode=%b seg=%h dp=%b, want 1111 7f 1",
                         i, anode_activate, led_segment, dp);
            end
        end
        enable = 1'b1;
        tick();
        checks++;
        if (anode_activate !== 4'b1011 || led_segment !== 7'h08 || dp !== 1'b0) begin
            errors++;
            $display("FAIL scan_while_disabled: anode=%b seg=%h dp=%b, want 1011 08 0",
                     anode_activate, led_segment, dp);
        end
    endtask

    task automatic test_reset_mid_conversion();
        int n;
        dp_mask = 4'b0000;
        capture(16'h2710, 1'b1);
        wait_busy(-1, n);
        capture(16'h04D2, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || overflow !== 1'b0 || anode_activate !== 4'b1111 ||
            led_segment !== 7'h7F || dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_conv: busy=%b ovf=%b anode=%b seg=%h dp=%b, want 0 0 1111 7f 1",
                     busy, overflow, anode_activate, led_segment, dp);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (anode_activate !== 4'b1110 || led_segment !== 7'h40 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_digit0: anode=%b seg=%h busy=%b, want 1110 40 0",
                     anode_activate, led_segment, busy);
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_decimal();
        test_blank();
        test_overflow();
        test_back_to_back();
        test_dp_enable();
        test_reset_mid_conversion();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
